// File: rtl/reg_view_ctrl.sv
// Register viewer: debounced next/prev buttons select a CPU register, which is read over the debug
// port on selection change, periodic refresh and reset release; a read that times out shows EEEEEEEE.

module reg_view_debounce #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any sample agreeing with the stable level restarts the qualification window.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                press_q  <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;
endmodule

module reg_view_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REFRESH_CYCLES  = 10000000,
    parameter int unsigned ACK_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic        dbg_req,
    output logic [4:0]  dbg_addr,
    input  logic        dbg_ack,
    input  logic [31:0] dbg_rdata,
    output logic [31:0] disp_value,
    output logic [4:0]  sel_index,
    output logic        disp_err
);
    typedef enum logic {S_IDLE, S_REQ} state_t;

    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    logic          press_next;
    logic          press_prev;
    logic [4:0]    sel_q;
    logic [4:0]    sel_d;
    logic          pending_q;
    logic          pending_d;
    logic          boot_q;
    logic [RW-1:0] ref_cnt_q;
    logic          tick;
    logic          start;
    state_t        state_q;
    logic [TW-1:0] wait_q;
    logic [4:0]    addr_q;
    logic          req_q;
    logic [31:0]   disp_q;
    logic          err_q;

    reg_view_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_next),
        .press_o (press_next)
    );

    reg_view_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_prev),
        .press_o (press_prev)
    );

    always_comb begin
        tick  = (ref_cnt_q == REF_LAST);
        start = (state_q == S_IDLE) && (pending_q || tick || boot_q);

        sel_d = sel_q;
        if (press_next && !press_prev) begin
            sel_d = sel_q + 5'd1;
        end else if (press_prev && !press_next) begin
            sel_d = sel_q - 5'd1;
        end

        // A selection change or refresh that cannot be served now is remembered for the next IDLE.
        pending_d = pending_q;
        if (start) begin
            pending_d = 1'b0;
        end
        if ((sel_d != sel_q) || (tick && (state_q == S_REQ))) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= 5'd0;
            pending_q <= 1'b0;
            ref_cnt_q <= '0;
        end else begin
            sel_q     <= sel_d;
            pending_q <= pending_d;
            ref_cnt_q <= tick ? '0 : ref_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            boot_q  <= 1'b1;
            wait_q  <= '0;
            addr_q  <= 5'd0;
            req_q   <= 1'b0;
            disp_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_REQ;
                        boot_q  <= 1'b0;
                        wait_q  <= '0;
                        addr_q  <= sel_q;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (dbg_ack) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        disp_q  <= dbg_rdata;
                        err_q   <= 1'b0;
                    end else if (wait_q == TO_LAST) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        disp_q  <= 32'hEEEEEEEE;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_req    = req_q;
    assign dbg_addr   = addr_q;
    assign disp_value = disp_q;
    assign sel_index  = sel_q;
    assign disp_err   = err_q;
endmodule

// File: tb/tb_reg_view_ctrl.sv
// Directed bench for reg_view_ctrl with short debounce/refresh/timeout parameters
// and an auto-acking register-file responder that can be swapped for manual acks.
module tb_reg_view_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [31:0] disp_value;
    logic [4:0]  sel_index;
    logic        disp_err;

    logic        resp_en = 1'b1;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = 32'd0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    logic [4:0]  last_req_addr = 5'd0;
    int          errors = 0;
    int          checks = 0;

    assign dbg_ack   = resp_en ? auto_ack : man_ack;
    assign dbg_rdata = resp_en ? auto_rdata : man_rdata;

    reg_view_ctrl #(.DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(64), .ACK_TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .disp_value (disp_value),
        .sel_index  (sel_index),
        .disp_err   (disp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_val(input logic [4:0] a);
        return 32'h12345678 + 32'(a) * 32'h00100001;
    endfunction

    // Responder: acks every request two cycles after it is first seen.
    initial begin : responder
        int wait_n;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                auto_ack = 1'b0;
                wait_n = 0;
            end else if (dbg_req && !auto_ack) begin
                if (wait_n >= 2) begin
                    auto_ack = 1'b1;
                    auto_rdata = rd_val(dbg_addr);
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end else begin
                auto_ack = 1'b0;
                wait_n = 0;
            end
        end
    end

    initial begin : addr_monitor
        forever begin
            @(negedge clk);
            if (dbg_req) last_req_addr = dbg_addr;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (dbg_req === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic disable_resp();
        for (int i = 0; i < 20; i++) begin
            if (dbg_req === 1'b0) break;
            @(negedge clk);
        end
        man_ack = 1'b0;
        resp_en = 1'b0;
    endtask

    task automatic press(input bit nxt, input bit prv, input int hold);
        btn_next = nxt;
        btn_prev = prv;
        cycles(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cycles(12);
    endtask

    task automatic test_reset();
        cycles(3);
        checks++; if (dbg_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dbg_req); end
        checks++; if (dbg_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", dbg_addr); end
        checks++; if (sel_index !== 5'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel_index); end
        checks++; if (disp_value !== 32'd0) begin errors++; $display("FAIL reset_disp: got %h want 0", disp_value); end
        checks++; if (disp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", disp_err); end
        reset = 1'b0;
    endtask

    task automatic test_first_read();
        bit ok;
        wait_req(1'b1, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL boot_req: got no request want request"); end
        checks++; if (dbg_addr !== 5'd0) begin errors++; $display("FAIL boot_addr: got %0d want 0", dbg_addr); end
        wait_req(1'b0, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL boot_done: got req stuck want release"); end
        checks++; if (disp_value !== 32'h12345678) begin errors++; $display("FAIL boot_disp: got %h want 12345678", disp_value); end
        checks++; if (disp_err !== 1'b0) begin errors++; $display("FAIL boot_err: got %b want 0", disp_err); end
    endtask

    task automatic test_debounce();
        press(1'b1, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            btn_next = 1'b1; cycles(1);
            btn_next = 1'b0; cycles(1);
        end
        cycles(10);
        checks++; if (sel_index !== 5'd0) begin errors++; $display("FAIL glitch_sel: got %0d want 0", sel_index); end
        press(1'b1, 1'b0, 10);
        cycles(8);
        checks++; if (sel_index !== 5'd1) begin errors++; $display("FAIL next_sel: got %0d want 1", sel_index); end
        checks++; if (last_req_addr !== 5'd1) begin errors++; $display("FAIL next_addr: got %0d want 1", last_req_addr); end
        checks++; if (disp_value !== rd_val(5'd1)) begin errors++; $display("FAIL next_disp: got %h want %h", disp_value, rd_val(5'd1)); end
    endtask

    task automatic test_prev_wrap();
        press(1'b0, 1'b1, 10);
        checks++; if (sel_index !== 5'd0) begin errors++; $display("FAIL prev_sel0: got %0d want 0", sel_index); end
        press(1'b0, 1'b1, 10);
        cycles(8);
        checks++; if (sel_index !== 5'd31) begin errors++; $display("FAIL prev_wrap: got %0d want 31", sel_index); end
        checks++; if (last_req_addr !== 5'd31) begin errors++; $display("FAIL prev_addr: got %0d want 31", last_req_addr); end
        checks++; if (disp_value !== rd_val(5'd31)) begin errors++; $display("FAIL prev_disp: got %h want %h", disp_value, rd_val(5'd31)); end
        press(1'b1, 1'b1, 10);
        checks++; if (sel_index !== 5'd31) begin errors++; $display("FAIL both_sel: got %0d want 31", sel_index); end
        press(1'b1, 1'b0, 10);
        checks++; if (sel_index !== 5'd0) begin errors++; $display("FAIL next_wrap: got %0d want 0", sel_index); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        disable_resp();
        wait_req(1'b1, 150, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_req: got no request want request"); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dbg_req) n++; else break;
        end
        resp_en = 1'b1;
        checks++; if (n != 8) begin errors++; $display("FAIL to_len: got %0d cycles want 8", n); end
        checks++; if (disp_value !== 32'hEEEEEEEE) begin errors++; $display("FAIL to_disp: got %h want eeeeeeee", disp_value); end
        checks++; if (disp_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", disp_err); end
        wait_req(1'b1, 150, ok);
        wait_req(1'b0, 20, ok);
        checks++; if (disp_err !== 1'b0) begin errors++; $display("FAIL to_clear_err: got %b want 0", disp_err); end
        checks++; if (disp_value !== rd_val(5'd0)) begin errors++; $display("FAIL to_clear_disp: got %h want %h", disp_value, rd_val(5'd0)); end
    endtask

    task automatic test_pending();
        bit ok;
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 10);
        checks++; if (sel_index !== 5'd3) begin errors++; $display("FAIL pend_sel3: got %0d want 3", sel_index); end
        cycles(80);
        wait_req(1'b1, 100, ok);
        wait_req(1'b0, 10, ok);
        disable_resp();
        cycles(57);
        btn_next = 1'b1;
        wait_req(1'b1, 10, ok);
        checks++; if (!ok || dbg_addr !== 5'd3) begin errors++; $display("FAIL pend_req3: got ok=%0b addr=%0d want ok=1 addr=3", ok, dbg_addr); end
        for (int i = 0; i < 7; i++) begin
            if (sel_index === 5'd4) break;
            @(negedge clk);
        end
        checks++; if (sel_index !== 5'd4) begin errors++; $display("FAIL pend_sel4: got %0d want 4", sel_index); end
        checks++; if (dbg_req !== 1'b1 || dbg_addr !== 5'd3) begin errors++; $display("FAIL pend_hold: got req=%b addr=%0d want req=1 addr=3", dbg_req, dbg_addr); end
        man_ack = 1'b1;
        man_rdata = rd_val(5'd3);
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (dbg_req !== 1'b0) begin errors++; $display("FAIL pend_capture_req: got %b want 0", dbg_req); end
        checks++; if (disp_value !== rd_val(5'd3)) begin errors++; $display("FAIL pend_capture: got %h want %h", disp_value, rd_val(5'd3)); end
        @(negedge clk);
        checks++; if (dbg_req !== 1'b1 || dbg_addr !== 5'd4) begin errors++; $display("FAIL pend_next_req: got req=%b addr=%0d want req=1 addr=4", dbg_req, dbg_addr); end
        btn_next = 1'b0;
        resp_en = 1'b1;
        cycles(20);
        checks++; if (disp_value !== rd_val(5'd4)) begin errors++; $display("FAIL pend_disp4: got %h want %h", disp_value, rd_val(5'd4)); end
    endtask

    task automatic test_reset_mid_req();
        bit ok;
        disable_resp();
        wait_req(1'b1, 150, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_req: got no request want request"); end
        #2 reset = 1'b1;
        #1;
        checks++; if (dbg_req !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b want 0", dbg_req); end
        checks++; if (sel_index !== 5'd0 || dbg_addr !== 5'd0) begin errors++; $display("FAIL rst_idx: got sel=%0d addr=%0d want 0 0", sel_index, dbg_addr); end
        checks++; if (disp_value !== 32'd0 || disp_err !== 1'b0) begin errors++; $display("FAIL rst_disp: got %h err=%b want 0 0", disp_value, disp_err); end
        @(negedge clk);
        reset = 1'b0;
        resp_en = 1'b1;
        wait_req(1'b1, 5, ok);
        checks++; if (!ok || dbg_addr !== 5'd0) begin errors++; $display("FAIL rst_boot: got ok=%0b addr=%0d want ok=1 addr=0", ok, dbg_addr); end
        wait_req(1'b0, 20, ok);
        checks++; if (disp_value !== rd_val(5'd0)) begin errors++; $display("FAIL rst_boot_disp: got %h want %h", disp_value, rd_val(5'd0)); end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_debounce();
        test_prev_wrap();
        test_timeout();
        test_pending();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_view_ctrl.md
REG_VIEW_CTRL -- requirements
Module: reg_view_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable samples required to accept a button level.
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 10000000, meaning the period between automatic re-reads of the selected register.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of cycles waited for dbg_ack.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port btn_next, input, 1 bit: raw, asynchronous pushbutton that selects the next register.
REQ-007 The block SHALL have port btn_prev, input, 1 bit: raw, asynchronous pushbutton that selects the previous register.
REQ-008 The block SHALL have port dbg_req, output, 1 bit: read request to the processor register-file debug port.
REQ-009 The block SHALL have port dbg_addr, output, 5 bits: register index being read.
REQ-010 The block SHALL have port dbg_ack, input, 1 bit: read data valid, sampled only while dbg_req=1.
REQ-011 The block SHALL have port dbg_rdata, input, 32 bits: register read data.
REQ-012 The block SHALL have port disp_value, output, 32 bits: the value fed to the 8-digit seven-segment driver.
REQ-013 The block SHALL have port sel_index, output, 5 bits: currently selected register index.
REQ-014 The block SHALL have port disp_err, output, 1 bit: last read timed out.

Function
REQ-015 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-016 A debouncer SHALL update its stable level only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the stable level; any sample equal to the stable level SHALL clear its counter.
REQ-017 A 0->1 transition of a stable level SHALL produce exactly one single-cycle press pulse.
REQ-018 A next pulse SHALL increment sel_index modulo 32 (31->0); a prev pulse SHALL decrement it modulo 32 (0->31); simultaneous pulses SHALL leave sel_index unchanged.
REQ-019 The FSM SHALL have states IDLE and REQ.
REQ-020 In IDLE, a pending flag, a refresh tick, or the first cycle after reset SHALL cause a transition to REQ on the next edge, with dbg_addr<=sel_index and dbg_req<=1, both registered.
REQ-021 The pending flag SHALL be set by any change of sel_index, and cleared when REQ is entered.
REQ-022 dbg_addr SHALL remain constant while in REQ, even if sel_index changes; such a change SHALL set the pending flag.
REQ-023 In REQ with dbg_ack=1, the next edge SHALL perform all of: disp_value<=dbg_rdata, disp_err<=0, dbg_req<=0, and return to IDLE.
REQ-024 In REQ, after ACK_TIMEOUT cycles without dbg_ack, the next edge SHALL perform all of: disp_value<=32'hEEEEEEEE, disp_err<=1, dbg_req<=0, and return to IDLE.
REQ-025 dbg_ack SHALL be ignored while dbg_req=0.
REQ-026 The refresh counter SHALL count 0..REFRESH_CYCLES-1 and issue one tick at wrap.
REQ-027 A tick arriving while in REQ SHALL set the pending flag, so that no more than one request is outstanding.
REQ-028 disp_value SHALL change only on the capture edges of REQ-023 and REQ-024, so the downstream multiplexed display never sees a partial word.

Reset
REQ-029 On reset, the block SHALL set sel_index=0, dbg_addr=0, dbg_req=0, disp_value=0, disp_err=0, the FSM to IDLE, the pending flag to 0, and all counters to 0.
REQ-030 On reset, debouncer stable levels and synchronizer flops SHALL be 0.
REQ-031 Reset asserted mid-REQ SHALL drop dbg_req immediately, asynchronously.
REQ-032 The first read of register 0 SHALL be issued automatically after reset release.

Verification
REQ-033 Bench parameters SHALL be DEBOUNCE_CYCLES=4, REFRESH_CYCLES=64, ACK_TIMEOUT=8.
REQ-034 Scenario: release reset, responder acks after 2 cycles with 32'h12345678 -> dbg_addr=0, disp_value=32'h12345678, disp_err=0.
REQ-035 Scenario: btn_next high for 3 cycles, then btn_next with 1-cycle glitches -> sel_index unchanged; btn_next held for 10 cycles -> exactly one increment to 1, then a read of addr 1.
REQ-036 Scenario: btn_prev pressed at sel_index=0 -> sel_index=31 and dbg_addr=31; both buttons pressed with identical timing -> no change.
REQ-037 Scenario: no ack is given -> after 8 cycles dbg_req=0, disp_value=32'hEEEEEEEE, disp_err=1; a later successful read clears disp_err.
REQ-038 Scenario: press next during an outstanding REQ to addr 3 -> the ack for addr 3 is captured, then a new REQ to addr 4 starts in the following IDLE cycle.
REQ-039 Scenario: assert reset during REQ -> dbg_req falls without a clock edge; all outputs return to their reset values.
